id_scoreboard: RTL
==================

# id_scoreboard

Register-hazard scoreboard that controls issue from the decode stage into the in-order EX/ME/WB pipeline. It holds a saturating pending-write counter for each architectural register and asserts a stall while the decode-stage instruction reads a register with a pending write. It also stalls when the instruction's destination counter is full. Counters increment when an instruction is handed from decode to EX and decrement when writeback writes the register file. This replaces per-stage destination comparison with one central tracker that is independent of pipeline depth.

## Interface
- CNT_W, 2: width of each per-register pending counter; max pending writes per register = 2^CNT_W-1
- NREG, 32: number of tracked architectural registers; index 0 is hard-wired zero and never tracked
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_src1_en  in  1  decode instruction reads id_src1 (rj port)
- id_src1  in  5  first source register
- id_src2_en  in  1  decode instruction reads id_src2 (rk/rd port)
- id_src2  in  5  second source register
- id_we  in  1  decode instruction writes a GPR
- id_dest  in  5  decode destination register
- issue_fire  in  1  decode instruction transfers to EX this cycle (ID valid, ready-go and EX allow-in)
- wb_we  in  1  writeback writes the register file this cycle
- wb_dest  in  5  writeback destination register
- flush  in  1  synchronous kill of every in-flight instruction; clears all counters
- stall  out  1  decode must not issue (combinational)
- busy  out  1  at least one counter is non-zero (registered)
- pending_total  out  7  sum of all counters (registered)
- err  out  1  sticky protocol error (registered)

## Operation
- State per register r in 1..NREG-1: cnt[r], CNT_W bits, unsigned. cnt[0] is constant 0.
- Hazard terms, all evaluated from registered cnt:
  - h1 = id_src1_en & id_src1!=0 & cnt[id_src1]!=0
  - h2 = id_src2_en & id_src2!=0 & cnt[id_src2]!=0
  - hf = id_we & id_dest!=0 & cnt[id_dest]==MAX
- stall = h1 | h2 | hf. There is no bypass: a register being written by WB this cycle still stalls decode this cycle, because the register file write lands at the clock edge.
- Per-register update at clk rising edge, in priority order:
  - flush=1: all cnt<=0. issue_fire and wb_we are ignored that cycle.
  - Otherwise, let inc = issue_fire & id_we & id_dest==r & r!=0 and dec = wb_we & wb_dest==r & r!=0.
    - inc & dec: cnt unchanged.
    - inc only: cnt+1. If cnt is already MAX, hold at MAX and set err.
    - dec only: cnt-1. If cnt is already 0, hold at 0 and set err.
- issue_fire while stall=1 is a protocol violation: set err and still apply the update.
- busy and pending_total are computed from the next-state counters and registered, so they reflect the counters after the same edge.
- err stays high until reset; flush does not clear it.

## Timing
- Reset, asynchronous: all cnt=0, busy=0, pending_total=0, err=0. stall is therefore 0 for any inputs.
- Reset deasserted mid-operation: the scoreboard starts empty. The pipeline is reset by the same signal, so nothing is in flight.
- The issue-to-hazard-visible latency is 1 cycle. If an instruction writing r5 fires in cycle N and the next instruction reads r5, stall is asserted in cycle N+1.
- Writeback-to-release latency is 1 cycle. If wb_we with wb_dest=r5 occurs in cycle M, stall on r5 drops in cycle M+1 when the count reaches 0.
- Counters never wrap, at either end.
- Simultaneous issue and writeback of the same register in one cycle leaves the count unchanged. Different registers update independently.
- There is no combinational path from issue_fire or wb_* to stall. stall depends only on the id_* inputs and registered state.

## Test plan
- **Reset check:** assert reset asynchronously mid-cycle with the r3 counter at 2. Required: cnt[3]=0, busy=0 and pending_total=0 immediately; stall=0 for id_src1=3.
- **RAW stall:** fire add r5 (id_we=1, id_dest=5), then present id_src1_en=1, id_src1=5. Required: stall=1 until the cycle after wb_we with wb_dest=5, then stall=0; pending_total goes 1 then 0.
- **Zero register:** fire id_dest=0 with id_we=1, then read r0 via id_src2. Required: stall=0, pending_total=0, err=0.
- **Saturation, CNT_W=2:** fire three writes to r7. Required: cnt[7]=3. A fourth decode instruction with id_we=1, id_dest=7 sees stall=1. Forcing issue_fire anyway holds pending_total at 3 and sets err=1.
- **Simultaneous events:** with cnt[9]=1, issue_fire to r9 and wb_we to r9 in the same cycle. Required: cnt[9]=1 and err=0. Then wb_we to r9 with cnt[9]=0 sets err=1.
- **Flush priority:** with cnt[4]=2 and cnt[6]=1, assert flush together with issue_fire to r4 and wb_we to r6. Required: next cycle busy=0, pending_total=0, stall=0 for reads of r4 and r6, and err unchanged.

Source files
------------

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard between decode and the in-order EX/ME/WB pipeline.
// Tracks one saturating pending-write counter per GPR and stalls decode on RAW or full-counter hazards.
module id_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_src1_en,
  input  logic [4:0] id_src1,
  input  logic       id_src2_en,
  input  logic [4:0] id_src2,
  input  logic       id_we,
  input  logic [4:0] id_dest,
  input  logic       issue_fire,
  input  logic       wb_we,
  input  logic [4:0] wb_dest,
  input  logic       flush,
  output logic       stall,
  output logic       busy,
  output logic [6:0] pending_total,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic             h1, h2, hf;
  logic             inc_r, dec_r;
  logic             err_set;
  logic [6:0]       total_nxt;

  // Hazards look only at registered counters: a same-cycle writeback does not release decode.
  assign h1    = id_src1_en && (id_src1 != 5'd0) && (cnt[id_src1] != '0);
  assign h2    = id_src2_en && (id_src2 != 5'd0) && (cnt[id_src2] != '0);
  assign hf    = id_we && (id_dest != 5'd0) && (cnt[id_dest] == CNT_MAX);
  assign stall = h1 | h2 | hf;

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so no path infers a latch.
    err_set   = issue_fire & stall & ~flush;
    total_nxt = '0;
    inc_r     = 1'b0;
    dec_r     = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      inc_r      = issue_fire & id_we & (id_dest == 5'(r));
      dec_r      = wb_we & (wb_dest == 5'(r));
      cnt_nxt[r] = cnt[r];
      if (flush || r == 0) begin
        cnt_nxt[r] = '0;
      end else if (inc_r && !dec_r) begin
        if (cnt[r] == CNT_MAX) err_set = 1'b1;
        else                   cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (dec_r && !inc_r) begin
        if (cnt[r] == '0) err_set = 1'b1;
        else              cnt_nxt[r] = cnt[r] - 1'b1;
      end
      total_nxt = total_nxt + 7'(cnt_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the counter array is reset, unlike a data RAM, because stall decodes it the cycle reset lifts.
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      busy          <= 1'b0;
      pending_total <= '0;
      err           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      busy          <= (total_nxt != '0);
      pending_total <= total_nxt;
      err           <= err | err_set;
    end
  end

endmodule
